rv32_wb_trace_tx: RTL and testbench

// - Consumer end of the iiitb_rv32i trace outputs: samples NPC and WB_OUT every clk.
// - Captures one record per new NPC value into a FIFO.
// - Transmits each record as a framed byte stream over a valid/ready handshake.
// - Sits beside the core in bench and FPGA builds, feeding a UART or logger, so

---
 rtl/rv32_wb_trace_tx.sv | 140 ++++++++++++++
 tb/tb_rv32_wb_trace_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_wb_trace_tx.sv
// Trace transmitter: captures {NPC, WB_OUT} whenever NPC changes and streams each
// record as a 9-byte frame (sync byte + 8 data bytes, MSB first) over valid/ready.
module rv32_wb_trace_tx #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        en,
    input  logic [31:0] NPC,
    input  logic [31:0] WB_OUT,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic [15:0] rec_count,
    output logic        fifo_empty
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t          state, state_nx;
    logic [63:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [63:0]     sreg, sreg_nx;
    logic [2:0]      idx, idx_nx;
    logic [7:0]      tx_data_nx;
    logic            tx_valid_nx;
    logic            have_prev;
    logic [31:0]     prev_npc;
    logic            full, cap, push, drop, pop, hs, rec_inc;

    assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign hs   = tx_valid & tx_ready;
    assign cap  = en & (!have_prev | (NPC != prev_npc));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = cap & (!full | pop);
    assign drop = cap & !push;
    assign wr_ptr_nx = wr_ptr + (ADDR_W+1)'(push);
    assign rd_ptr_nx = rd_ptr + (ADDR_W+1)'(pop);

    always_comb begin
        state_nx    = state;
        sreg_nx     = sreg;
        idx_nx      = idx;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;
        pop         = 1'b0;
        rec_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    sreg_nx     = mem[rd_ptr[ADDR_W-1:0]];
                    tx_data_nx  = SYNC_BYTE;
                    tx_valid_nx = 1'b1;
                    state_nx    = HDR;
                end else begin
                    tx_valid_nx = 1'b0;
                end
            end
            HDR: begin
                if (hs) begin
                    tx_data_nx = sreg[63:56];
                    sreg_nx    = {sreg[55:0], 8'h00};
                    idx_nx     = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    if (idx == 3'd7) begin
                        rec_inc = 1'b1;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            sreg_nx    = mem[rd_ptr[ADDR_W-1:0]];
                            tx_data_nx = SYNC_BYTE;
                            state_nx   = HDR;
                        end else begin
                            tx_valid_nx = 1'b0;
                            state_nx    = IDLE;
                        end
                    end else begin
                        tx_data_nx = sreg[63:56];
                        sreg_nx    = {sreg[55:0], 8'h00};
                        idx_nx     = idx + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RN) state <= IDLE;
        else    state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= {NPC, WB_OUT};
    end

    always_ff @(posedge clk) begin
        if (RN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_empty <= 1'b1;
            sreg       <= '0;
            idx        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            have_prev  <= 1'b0;
            prev_npc   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            rec_count  <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            fifo_empty <= (wr_ptr_nx == rd_ptr_nx);
            sreg       <= sreg_nx;
            idx        <= idx_nx;
            tx_data    <= tx_data_nx;
            tx_valid   <= tx_valid_nx;
            rec_count  <= rec_count + 16'(rec_inc);
            if (cap) begin
                prev_npc  <= NPC;
                have_prev <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_wb_trace_tx.sv
// Directed bench for rv32_wb_trace_tx: framing, dedup, stall, overflow,
// full-FIFO pop+push and mid-frame reset.
module tb_rv32_wb_trace_tx;

    logic        clk = 1'b0;
    logic        RN, en, tx_ready, tx_valid, overflow, fifo_empty;
    logic [31:0] NPC, WB_OUT;
    logic [7:0]  tx_data;
    logic [15:0] drop_count, rec_count;

    int errors = 0;
    int checks = 0;

    rv32_wb_trace_tx #(.DEPTH(16), .ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .RN(RN), .en(en), .NPC(NPC), .WB_OUT(WB_OUT),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overflow(overflow), .drop_count(drop_count), .rec_count(rec_count),
        .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] n, input logic [31:0] w, input int i);
        logic [63:0] r;
        r = {n, w};
        if (i == 0) return 8'hA5;
        return r[(8 - i) * 8 +: 8];
    endfunction

    task automatic test_reset();
        RN = 1'b1; en = 1'b0; NPC = '0; WB_OUT = '0; tx_ready = 1'b0;
        step(); step();
        checks++; if (tx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
        checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || rec_count !== 16'd0) begin
            errors++; $display("FAIL reset_counters ovf=%0b drop=%0d rec=%0d exp=0/0/0", overflow, drop_count, rec_count);
        end
    endtask

    task automatic test_basic_frame();
        RN = 1'b0; en = 1'b1; NPC = 32'h4; WB_OUT = 32'h11; tx_ready = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0 || fifo_empty !== 1'b0) begin
            errors++; $display("FAIL basic_latency1 valid=%0b empty=%0b exp valid=0 empty=0", tx_valid, fifo_empty);
        end
        step();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(32'h4, 32'h11, i)) begin
                errors++; $display("FAIL basic_byte%0d valid=%0b got=%h exp=%h", i, tx_valid, tx_data, exp_byte(32'h4, 32'h11, i));
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0 || rec_count !== 16'd1 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL basic_end valid=%0b rec=%0d empty=%0b exp 0/1/1", tx_valid, rec_count, fifo_empty);
        end
    endtask

    task automatic test_npc_hold();
        int nb = 0;
        NPC = 32'h8;
        for (int c = 0; c < 25; c++) begin
            if (c < 10) WB_OUT = 32'h100 + 32'(c);
            step();
            if (tx_valid === 1'b1) begin
                if (nb < 9) begin
                    checks++;
                    if (tx_data !== exp_byte(32'h8, 32'h100, nb)) begin
                        errors++; $display("FAIL hold_byte%0d got=%h exp=%h", nb, tx_data, exp_byte(32'h8, 32'h100, nb));
                    end
                end
                nb++;
            end
        end
        checks++; if (nb != 9 || rec_count !== 16'd2) begin
            errors++; $display("FAIL hold_count bytes=%0d rec=%0d exp bytes=9 rec=2", nb, rec_count);
        end
    endtask

    task automatic test_stall();
        int t = 0;
        NPC = 32'hC; WB_OUT = 32'hDEADBEEF;
        while (tx_valid !== 1'b1 && t < 10) begin step(); t++; end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_start valid=%0b exp=1 (timeout)", tx_valid); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(32'hC, 32'hDEADBEEF, k)) begin
                errors++; $display("FAIL stall_byte%0d valid=%0b got=%h exp=%h", k, tx_valid, tx_data, exp_byte(32'hC, 32'hDEADBEEF, k));
            end
            if (k == 4) begin
                tx_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h0C) begin
                        errors++; $display("FAIL stall_hold%0d valid=%0b got=%h exp=0c", s, tx_valid, tx_data);
                    end
                end
                tx_ready = 1'b1;
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0 || rec_count !== 16'd3) begin
            errors++; $display("FAIL stall_end valid=%0b rec=%0d exp 0/3", tx_valid, rec_count);
        end
    endtask

    // Record 0 is already popped into the shift register while stalled, so
    // 21 captures leave 16 queued + 1 in flight and 4 dropped.
    task automatic test_overflow_and_full_push();
        logic [31:0] en_npc, en_wb;
        tx_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            NPC = 32'h1000 + 32'(i * 4); WB_OUT = 32'hA000 + 32'(i);
            step();
        end
        en = 1'b0;
        checks++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin
            errors++; $display("FAIL ovf_flags ovf=%0b drop=%0d exp 1/4", overflow, drop_count);
        end
        checks++; if (fifo_empty !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL ovf_hold empty=%0b valid=%0b data=%h exp 0/1/a5", fifo_empty, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        for (int p = 0; p < 162; p++) begin
            if (p / 9 < 17) begin
                en_npc = 32'h1000 + 32'((p / 9) * 4); en_wb = 32'hA000 + 32'(p / 9);
            end else begin
                en_npc = 32'h2000; en_wb = 32'h77;
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(en_npc, en_wb, p % 9)) begin
                errors++; $display("FAIL stream_pos%0d valid=%0b got=%h exp=%h", p, tx_valid, tx_data, exp_byte(en_npc, en_wb, p % 9));
            end
            if (p == 8) begin en = 1'b1; NPC = 32'h2000; WB_OUT = 32'h77; end
            if (p == 9) en = 1'b0;
            step();
        end
        checks++; if (tx_valid !== 1'b0 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL stream_end valid=%0b empty=%0b exp 0/1", tx_valid, fifo_empty);
        end
        checks++; if (drop_count !== 16'd4 || rec_count !== 16'd21) begin
            errors++; $display("FAIL stream_counts drop=%0d rec=%0d exp 4/21", drop_count, rec_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            NPC = 32'h3000 + 32'(i * 4); WB_OUT = 32'hC0DE0000 + 32'(i);
            step();
        end
        en = 1'b0; tx_ready = 1'b1;
        repeat (5) step();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
            errors++; $display("FAIL rst_byte5 valid=%0b got=%h exp=c0", tx_valid, tx_data);
        end
        RN = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state valid=%0b data=%h empty=%0b exp 0/00/1", tx_valid, tx_data, fifo_empty);
        end
        checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || rec_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid_counters ovf=%0b drop=%0d rec=%0d exp 0/0/0", overflow, drop_count, rec_count);
        end
        // NPC unchanged from before reset: the first enabled cycle must still capture.
        RN = 1'b0; en = 1'b1;
        step();
        checks++; if (fifo_empty !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL rst_recapture empty=%0b valid=%0b exp 0/0", fifo_empty, tx_valid);
        end
        step();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_byte(32'h300C, 32'hC0DE0003, i)) begin
                errors++; $display("FAIL rst_frame_byte%0d valid=%0b got=%h exp=%h", i, tx_valid, tx_data, exp_byte(32'h300C, 32'hC0DE0003, i));
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0 || rec_count !== 16'd1 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL rst_frame_end valid=%0b rec=%0d empty=%0b exp 0/1/1", tx_valid, rec_count, fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_npc_hold();
        test_stall();
        test_overflow_and_full_push();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
